// File: rtl/output_router_pkg.sv
// Shared types and helpers for the output router: FSM state encoding and
// the requantization saturation function.
package output_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Internal working width for saturation; must exceed any ACC_WIDTH used.
  localparam int SAT_WIDTH = 64;

  // Clamp a sign-extended accumulator value to the signed range of
  // data_width bits. When the data word is at least as wide as the
  // accumulator no clamping can be needed, so the value passes through.
  function automatic logic signed [SAT_WIDTH-1:0] saturate(
    input logic signed [SAT_WIDTH-1:0] v,
    input int                          acc_width,
    input int                          data_width
  );
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    logic signed [SAT_WIDTH-1:0] res;
    max_v = $signed((64'd1 << (data_width - 1)) - 64'd1);
    min_v = -max_v - 64'sd1;
    res   = v;
    if (data_width < acc_width) begin
      if (v > max_v) begin
        res = max_v;
      end else if (v < min_v) begin
        res = min_v;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/output_router_psum_quantizer.sv
// Per-lane requantizer: arithmetic right shift of a signed partial sum
// followed by saturation to the output data width. Purely combinational.
module psum_quantizer
  import output_router_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic signed [ACC_WIDTH-1:0]   i_psum,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  output logic signed [DATA_WIDTH-1:0]  o_data
);

  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic signed [SAT_WIDTH-1:0]  w_wide;
  logic signed [SAT_WIDTH-1:0]  w_sat;
  logic [SAT_WIDTH-DATA_WIDTH-1:0] w_unused_hi;

  // Signed operand makes >>> an arithmetic shift (rounds toward -inf).
  assign w_shifted   = i_psum >>> i_shift;
  assign w_wide      = {{(SAT_WIDTH - ACC_WIDTH){w_shifted[ACC_WIDTH-1]}}, w_shifted};
  assign w_sat       = saturate(w_wide, ACC_WIDTH, DATA_WIDTH);
  // After saturation the value fits in DATA_WIDTH bits; the rest is sign.
  assign o_data      = w_sat[DATA_WIDTH-1:0];
  assign w_unused_hi = w_sat[SAT_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/output_router.sv
// Output router: captures requantized row partial sums on a strobe and
// drains them one word per cycle into the output buffer. The write pointer
// persists across contexts and only returns to zero on reset or clear.
module output_router
  import output_router_pkg::*;
#(
  parameter int ROUTER_COUNT = 2,
  parameter int ACC_WIDTH    = 32,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int SHIFT_WIDTH  = $clog2(ACC_WIDTH)
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  logic                             i_reg_clear,
  input  logic                             i_psum_out_en,
  input  logic [ROUTER_COUNT*ACC_WIDTH-1:0] i_psum,
  input  logic                             i_en,
  input  logic [ADDR_WIDTH-1:0]            i_route_size,
  input  logic [SHIFT_WIDTH-1:0]           i_shift,
  output logic                             o_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_addr,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_done
);

  // Lane counter must be able to hold ROUTER_COUNT itself.
  localparam int CNT_WIDTH = $clog2(ROUTER_COUNT + 1);
  localparam int IDX_WIDTH = (ROUTER_COUNT > 1) ? $clog2(ROUTER_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LANES = ADDR_WIDTH'(ROUTER_COUNT);

  state_t r_state;
  state_t w_state_next;

  logic signed [DATA_WIDTH-1:0] r_hold [ROUTER_COUNT];
  logic signed [DATA_WIDTH-1:0] w_quant [ROUTER_COUNT];
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;

  logic                  w_clear;
  logic [CNT_WIDTH-1:0]  w_count;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_capture;
  logic                  w_write;
  logic                  w_done_next;

  assign w_clear    = !i_nrst || i_reg_clear;
  assign w_count    = (i_route_size > LANES) ? CNT_WIDTH'(ROUTER_COUNT)
                                             : i_route_size[CNT_WIDTH-1:0];
  assign w_last     = (r_idx + CNT_WIDTH'(1)) == r_count;
  assign w_sel_data = r_hold[r_idx[IDX_WIDTH-1:0]];

  generate
    for (genvar gi = 0; gi < ROUTER_COUNT; gi++) begin : g_lane
      psum_quantizer #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_quant (
        .i_psum (i_psum[gi*ACC_WIDTH +: ACC_WIDTH]),
        .i_shift(i_shift),
        .o_data (w_quant[gi])
      );
    end
  endgenerate

  // State register; clear dominates every other input.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_psum_out_en) begin
          w_state_next = (w_count == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (i_en && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output/datapath decode for the current state.
  always_comb begin
    w_capture   = 1'b0;
    w_write     = 1'b0;
    w_done_next = 1'b0;
    case (r_state)
      IDLE:    w_capture   = i_psum_out_en;
      DRAIN:   w_write     = i_en;
      DONE:    w_done_next = 1'b1;
      default: ;
    endcase
  end

  // Holding registers, pointer, lane index and registered outputs.
  // o_addr/o_data keep their last value when no write is issued.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      for (int i = 0; i < ROUTER_COUNT; i++) begin
        r_hold[i] <= '0;
      end
      r_count <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_wr_en <= w_write;
      r_done  <= w_done_next;
      if (w_capture) begin
        for (int i = 0; i < ROUTER_COUNT; i++) begin
          r_hold[i] <= w_quant[i];
        end
        r_count <= w_count;
        r_idx   <= '0;
      end
      if (w_write) begin
        r_addr <= r_ptr;
        r_data <= w_sel_data;
        r_ptr  <= r_ptr + ADDR_WIDTH'(1);
        r_idx  <= r_idx + CNT_WIDTH'(1);
      end
    end
  end

  assign o_wr_en = r_wr_en;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_done  = r_done;

endmodule

// File: tb/tb_output_router.sv
// Directed testbench for output_router with hand-computed expectations.
module tb_output_router;

  localparam int ROUTER_COUNT = 2;
  localparam int ACC_WIDTH    = 32;
  localparam int DATA_WIDTH   = 8;
  localparam int ADDR_WIDTH   = 8;
  localparam int SHIFT_WIDTH  = $clog2(ACC_WIDTH);

  logic                              i_clk;
  logic                              i_nrst;
  logic                              i_reg_clear;
  logic                              i_psum_out_en;
  logic [ROUTER_COUNT*ACC_WIDTH-1:0] i_psum;
  logic                              i_en;
  logic [ADDR_WIDTH-1:0]             i_route_size;
  logic [SHIFT_WIDTH-1:0]            i_shift;
  logic                              o_wr_en;
  logic [ADDR_WIDTH-1:0]             o_addr;
  logic [DATA_WIDTH-1:0]             o_data;
  logic                              o_done;

  int n_checks = 0;
  int n_errors = 0;

  output_router #(
    .ROUTER_COUNT(ROUTER_COUNT),
    .ACC_WIDTH   (ACC_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_reg_clear  (i_reg_clear),
    .i_psum_out_en(i_psum_out_en),
    .i_psum       (i_psum),
    .i_en         (i_en),
    .i_route_size (i_route_size),
    .i_shift      (i_shift),
    .o_wr_en      (o_wr_en),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a context strobe for one cycle.
  task automatic start_ctx(input int p0, input int p1, input int sh, input int size);
    i_psum        = {32'(p1), 32'(p0)};
    i_shift       = SHIFT_WIDTH'(sh);
    i_route_size  = ADDR_WIDTH'(size);
    i_psum_out_en = 1'b1;
    tick();
    i_psum_out_en = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int addr, input int data);
    tick();
    check({tag, ".wr_en"}, 32'(o_wr_en), 1);
    check({tag, ".addr"},  32'(o_addr), addr);
    check({tag, ".data"},  $signed(o_data), data);
    $display("write %s: addr=%0d data=%0d", tag, o_addr, $signed(o_data));
  endtask

  task automatic expect_quiet(input string tag, input int done);
    tick();
    check({tag, ".wr_en"}, 32'(o_wr_en), 0);
    check({tag, ".done"},  32'(o_done), done);
    $display("cycle %s: wr_en=%0d done=%0d", tag, o_wr_en, o_done);
  endtask

  initial begin
    i_nrst        = 1'b0;
    i_reg_clear   = 1'b0;
    i_psum_out_en = 1'b0;
    i_psum        = '0;
    i_en          = 1'b0;
    i_route_size  = '0;
    i_shift       = '0;
    tick();
    tick();
    check("rst.wr_en", 32'(o_wr_en), 0);
    check("rst.addr",  32'(o_addr), 0);
    check("rst.data",  32'(o_data), 0);
    check("rst.done",  32'(o_done), 0);
    i_nrst = 1'b1;
    i_en   = 1'b1;

    // Basic drain: lane0=-12, lane1=40
    start_ctx(-12, 40, 0, 2);
    expect_write("basic0", 0, -12);
    expect_write("basic1", 1, 40);
    expect_quiet("basic_done", 1);
    expect_quiet("basic_after", 0);

    // Saturation and shift: 1000>>>2=250 -> 127 ; -5>>>2 = -2
    start_ctx(1000, -5, 2, 2);
    expect_write("sat_pos", 2, 127);
    expect_write("shift2_neg", 3, -2);
    expect_quiet("sat_done", 1);
    // -1000>>>1=-500 -> -128 ; -5>>>1 = -3
    start_ctx(-1000, -5, 1, 2);
    expect_write("sat_neg", 4, -128);
    expect_write("shift1_neg", 5, -3);
    expect_quiet("sat2_done", 1);
    // -1000 with no shift saturates low as well
    start_ctx(-1000, 100, 0, 2);
    expect_write("sat_neg0", 6, -128);
    expect_write("pass100", 7, 100);
    expect_quiet("sat3_done", 1);

    // Stall: three bubble cycles after the first write
    start_ctx(7, -9, 0, 2);
    expect_write("stall0", 8, 7);
    i_en = 1'b0;
    expect_quiet("stall_gap0", 0);
    expect_quiet("stall_gap1", 0);
    expect_quiet("stall_gap2", 0);
    i_en = 1'b1;
    expect_write("stall1", 9, -9);
    expect_quiet("stall_done", 1);

    // Zero lanes: no write, done two cycles after strobe
    start_ctx(1, 2, 0, 0);
    check("zero.wr_en", 32'(o_wr_en), 0);
    check("zero.done",  32'(o_done), 0);
    expect_quiet("zero_done", 1);
    expect_quiet("zero_after", 0);

    // Oversized route_size clamps to two writes
    start_ctx(3, -4, 0, 5);
    expect_write("big0", 10, 3);
    expect_write("big1", 11, -4);
    expect_quiet("big_done", 1);

    // Strobe during DRAIN is ignored, then clear mid-drain
    i_en = 1'b0;
    start_ctx(11, 22, 0, 2);
    start_ctx(99, 99, 0, 2);
    i_en = 1'b1;
    expect_write("ign0", 12, 11);
    i_reg_clear = 1'b1;
    tick();
    check("clr.wr_en", 32'(o_wr_en), 0);
    check("clr.addr",  32'(o_addr), 0);
    check("clr.data",  32'(o_data), 0);
    check("clr.done",  32'(o_done), 0);
    i_reg_clear = 1'b0;
    expect_quiet("clr_idle", 0);
    start_ctx(5, 6, 0, 2);
    expect_write("post_clr0", 0, 5);
    expect_write("post_clr1", 1, 6);
    expect_quiet("post_clr_done", 1);

    // Walk the pointer up to 254 (126 contexts of 2 writes from addr 2)
    for (int k = 0; k < 126; k++) begin
      start_ctx(1, 2, 0, 2);
      tick();
      tick();
      tick();
    end
    start_ctx(9, 0, 0, 1);
    expect_write("wrap_pre", 254, 9);
    expect_quiet("wrap_pre_done", 1);
    start_ctx(10, -10, 0, 2);
    expect_write("wrap255", 255, 10);
    expect_write("wrap0", 0, -10);
    expect_quiet("wrap_done", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_router.md
# output_router

Drains partial sums from the array's row outputs into the output buffer, one word per cycle, after requantizing each to the buffer's data width. Sits directly downstream of the top-level controller and the PE array:
- `i_psum_out_en` captures the row sums.
- `i_en` gates draining.
- `o_done` returns to the controller as its output-router-done input.

The write pointer persists across contexts, so successive tiles land at consecutive buffer addresses until `i_reg_clear`.

## Interface
- ROUTER_COUNT, 2: number of array rows, i.e. psum lanes captured per context.
- ACC_WIDTH, 32: signed width of each incoming partial sum.
- DATA_WIDTH, 8: signed width of each written output word.
- ADDR_WIDTH, 8: output-buffer address width.
- SHIFT_WIDTH, $clog2(ACC_WIDTH): width of the requantization shift amount.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_nrst  in  1  reset; synchronous, active-low.
- i_reg_clear  in  1  synchronous soft clear; same effect as reset.
- i_psum_out_en  in  1  one-cycle strobe that captures i_psum.
- i_psum  in  ROUTER_COUNT×ACC_WIDTH  packed signed row sums; lane 0 in the LSBs.
- i_en  in  1  drain enable; level signal.
- i_route_size  in  ADDR_WIDTH  number of valid lanes this context. Sampled with i_psum_out_en.
- i_shift  in  SHIFT_WIDTH  arithmetic right-shift amount. Sampled with i_psum_out_en.
- o_wr_en  out  1  output-buffer write strobe.
- o_addr  out  ADDR_WIDTH  write address.
- o_data  out  DATA_WIDTH  signed write data.
- o_done  out  1  one-cycle pulse: the context is fully written.

## Operation
- Reset or i_reg_clear:
  - state IDLE.
  - Outputs o_wr_en, o_addr, o_data and o_done are all 0.
  - Write pointer, lane index and holding registers are 0.
  - i_reg_clear takes priority over every other input.
- Requantization is applied per lane at capture:
  - v = i_psum[lane] >>> i_shift (arithmetic, truncating toward −∞).
  - Saturate v to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Lane count: count = min(i_route_size, ROUTER_COUNT). A count of 0 means no writes.
- States:
  - IDLE: on i_psum_out_en, latch the requantized lanes and count, set the lane index to 0, and go to DRAIN. If count is 0, go to DONE instead.
  - DRAIN, i_en=1: register o_wr_en=1, o_addr=ptr, o_data=hold[idx]; then ptr++ and idx++. When idx reaches count−1, this write is the last one and the state becomes DONE.
  - DRAIN, i_en=0: o_wr_en=0; idx and ptr hold (stall).
  - DONE: o_wr_en=0 and o_done=1 for exactly one cycle, then go to IDLE.
- i_psum_out_en outside IDLE is ignored; the holding registers are not overwritten.
- ptr wraps modulo 2^ADDR_WIDTH with no flag. It is not reset between contexts.

## Timing
- i_psum_out_en sampled at edge t → DRAIN at t+1. The first write is visible after the first edge in DRAIN at which i_en=1.
- With i_en held high, count writes occur on consecutive cycles.
- o_done is high in the cycle immediately after the last o_wr_en cycle.
- Minimum context latency, strobe to o_done: count+2 cycles. With count=0: 2 cycles.
- o_addr and o_data are only meaningful while o_wr_en=1; otherwise they hold their last value.
- Deasserting i_en mid-drain inserts bubbles only. No data is lost or reordered.

## Structure
- Shared package output_router_pkg holds:
  - the state enum (IDLE, DRAIN, DONE);
  - a saturate function parameterized by ACC_WIDTH and DATA_WIDTH.
- One sub-module, psum_quantizer: combinational shift plus saturate for one lane, instantiated ROUTER_COUNT times in a generate loop.
- The top holds the FSM, the holding registers, the pointer and the lane index.

## Test plan
- Basic drain: ROUTER_COUNT=2, i_psum={40,−12}, i_shift=0, route_size=2, i_en=1.
  - Expect writes (addr0,−12) then (addr1,40) on consecutive cycles.
  - Expect o_done high the next cycle for 1 cycle.
- Saturation and shift:
  - psum=1000, shift=2 → 127.
  - psum=−1000, shift=0 → −128.
  - psum=−5, shift=1 → −3.
- Stall: drop i_en for 3 cycles after the first write.
  - Expect no writes during the gap, the second write at addr1 afterwards, and o_done delayed by 3 cycles.
- Pointer persistence and wrap:
  - Two contexts back-to-back → addresses 0,1,2,3.
  - Preload ptr to 255 with ADDR_WIDTH=8 → addresses 255 then 0.
- Edge counts:
  - route_size=0 → no o_wr_en; o_done 2 cycles after the strobe.
  - route_size=5 with ROUTER_COUNT=2 → exactly 2 writes.
- Clear mid-drain: assert i_reg_clear during DRAIN.
  - Expect all outputs 0 next cycle and state IDLE.
  - The next context writes from addr0.
  - A strobe arriving during DRAIN is ignored.
